xip_axi_burst_adapter: RTL and testbench

Upstream front end of `xip_engine`. It accepts AXI4 read bursts (INCR, FIXED, WRAP; 32-bit beats) from the system interconnect. Each beat becomes one single-word AXI-Lite read on the `xip_engine` read port, and the words come back as a burst with `rid` and `rlast`. Exactly one downstream read is outstanding at any time. Each result word is held in a one-entry response register until the master accepts it.

---
 rtl/xip_axi_burst_adapter.sv | 175 +++++++++++++++++
 tb/tb_xip_axi_burst_adapter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xip_axi_burst_adapter.sv
`default_nettype none
// ============================================================================
// Module   : xip_axi_burst_adapter
// Brief    : Turns AXI4 read bursts into single-word AXI-Lite reads for xip_engine
// Revision : 1.0
// ============================================================================
module xip_axi_burst_adapter #(
  parameter int ID_W = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [ID_W-1:0] s_arid,
  input  logic [31:0]     s_araddr,
  input  logic [7:0]      s_arlen,
  input  logic [2:0]      s_arsize,
  input  logic [1:0]      s_arburst,
  input  logic            s_arvalid,
  output logic            s_arready,
  output logic [ID_W-1:0] s_rid,
  output logic [31:0]     s_rdata,
  output logic [1:0]      s_rresp,
  output logic            s_rlast,
  output logic            s_rvalid,
  input  logic            s_rready,
  output logic [31:0]     m_araddr,
  output logic            m_arvalid,
  input  logic            m_arready,
  input  logic [31:0]     m_rdata,
  input  logic [1:0]      m_rresp,
  input  logic            m_rvalid,
  output logic            m_rready,
  output logic            busy_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT_R = 3'd2,
    ST_RESP   = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

  localparam logic [1:0] C_FIXED  = 2'b00;
  localparam logic [1:0] C_INCR   = 2'b01;
  localparam logic [1:0] C_WRAP   = 2'b10;
  localparam logic [1:0] C_SLVERR = 2'b10;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [7:0]  r_beat;
  logic [1:0]  r_burst;

  logic        w_wrap_len_ok;
  logic        w_illegal;
  logic [31:0] w_incr_addr;
  logic [31:0] w_wrap_mask;
  logic [31:0] w_next_addr;

  assign w_wrap_len_ok = (s_arlen == 8'd1) || (s_arlen == 8'd3) ||
                         (s_arlen == 8'd7) || (s_arlen == 8'd15);
  assign w_illegal     = (s_arsize != 3'b010) || (s_arburst == 2'b11) ||
                         ((s_arburst == C_WRAP) &&
                          (!w_wrap_len_ok || (s_araddr[1:0] != 2'b00)));

  // (len+1)*4-1 reduces to {len, 2'b11}
  assign w_incr_addr = r_addr + 32'd4;
  assign w_wrap_mask = {22'd0, r_len, 2'b11};

  always_comb begin
    w_next_addr = r_addr;
    case (r_burst)
      C_FIXED: w_next_addr = r_addr;
      C_INCR:  w_next_addr = {r_addr[31:12], w_incr_addr[11:0]};
      C_WRAP:  w_next_addr = (r_addr & ~w_wrap_mask) | (w_incr_addr & w_wrap_mask);
      default: w_next_addr = r_addr;
    endcase
  end

  assign busy_o = (r_state != ST_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_addr    <= 32'd0;
      r_len     <= 8'd0;
      r_beat    <= 8'd0;
      r_burst   <= 2'b00;
      s_arready <= 1'b0;
      s_rid     <= '0;
      s_rdata   <= 32'd0;
      s_rresp   <= 2'b00;
      s_rlast   <= 1'b0;
      s_rvalid  <= 1'b0;
      m_araddr  <= 32'd0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          s_arready <= 1'b1;
          if (s_arready && s_arvalid) begin
            s_arready <= 1'b0;
            s_rid     <= s_arid;
            r_addr    <= s_araddr;
            r_len     <= s_arlen;
            r_burst   <= s_arburst;
            r_beat    <= 8'd0;
            if (w_illegal) begin
              r_state  <= ST_ERR;
              s_rvalid <= 1'b1;
              s_rdata  <= 32'd0;
              s_rresp  <= C_SLVERR;
              s_rlast  <= (s_arlen == 8'd0);
            end else begin
              r_state   <= ST_ISSUE;
              m_arvalid <= 1'b1;
              m_araddr  <= {s_araddr[31:2], 2'b00};
            end
          end
        end
        ST_ISSUE: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            r_state   <= ST_WAIT_R;
          end
        end
        ST_WAIT_R: begin
          if (m_rvalid) begin
            m_rready <= 1'b0;
            s_rvalid <= 1'b1;
            s_rdata  <= m_rdata;
            s_rresp  <= m_rresp;
            s_rlast  <= (r_beat == r_len);
            r_state  <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (s_rready) begin
            s_rvalid <= 1'b0;
            if (s_rlast) begin
              s_arready <= 1'b1;
              r_state   <= ST_IDLE;
            end else begin
              r_beat    <= r_beat + 8'd1;
              r_addr    <= w_next_addr;
              m_araddr  <= {w_next_addr[31:2], 2'b00};
              m_arvalid <= 1'b1;
              r_state   <= ST_ISSUE;
            end
          end
        end
        ST_ERR: begin
          // Error beats are generated locally, one per accepted handshake
          if (s_rready) begin
            if (s_rlast) begin
              s_rvalid  <= 1'b0;
              s_rlast   <= 1'b0;
              s_rresp   <= 2'b00;
              s_arready <= 1'b1;
              r_state   <= ST_IDLE;
            end else begin
              r_beat  <= r_beat + 8'd1;
              s_rlast <= ((r_beat + 8'd1) == r_len);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xip_axi_burst_adapter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_xip_axi_burst_adapter
// Brief    : Directed plus random burst bench with a transaction-level reference model
// Revision : 1.0
// ============================================================================
module tb_xip_axi_burst_adapter;
  localparam int ID_W = 4;
  localparam int TMO  = 200;

  logic            clk = 1'b0;
  logic            resetn = 1'b1;
  logic [ID_W-1:0] s_arid = '0;
  logic [31:0]     s_araddr = '0;
  logic [7:0]      s_arlen = '0;
  logic [2:0]      s_arsize = 3'b010;
  logic [1:0]      s_arburst = 2'b01;
  logic            s_arvalid = 1'b0;
  logic            s_arready;
  logic [ID_W-1:0] s_rid;
  logic [31:0]     s_rdata;
  logic [1:0]      s_rresp;
  logic            s_rlast;
  logic            s_rvalid;
  logic            s_rready = 1'b0;
  logic [31:0]     m_araddr;
  logic            m_arvalid;
  logic            m_arready;
  logic [31:0]     m_rdata;
  logic [1:0]      m_rresp;
  logic            m_rvalid;
  logic            m_rready;
  logic            busy_o;

  xip_axi_burst_adapter #(.ID_W(ID_W)) dut (
    .clk(clk), .resetn(resetn),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Downstream slave model state
  logic [31:0] ds_base = '0;
  int          ds_err_beat = -1;
  int          ds_cnt = 0;
  logic [31:0] ds_addr_q[$];
  bit          ds_busy = 0, ar_hs = 0, r_hs = 0;
  int          ds_wait = 0;

  // Current burst as seen by the reference model
  logic [ID_W-1:0] cur_id;
  logic [31:0]     cur_addr;
  int              cur_len;
  logic [1:0]      cur_burst;
  bit              cur_illegal;
  bit              in_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_illegal(input logic [31:0] a, input int len,
                                       input logic [2:0] size, input logic [1:0] burst);
    bit wrap_len_ok = (len == 1) || (len == 3) || (len == 7) || (len == 15);
    return (size != 3'b010) || (burst == 2'b11) ||
           (burst == 2'b10 && (!wrap_len_ok || (a % 4) != 0));
  endfunction

  function automatic logic [31:0] model_addr(input logic [31:0] start, input logic [1:0] burst,
                                             input int len, input int beat);
    longint unsigned s, a, span, base;
    logic [31:0] r;
    s = longint'(start);
    case (burst)
      2'b00:   a = s;
      2'b01:   a = (s - (s % 4096)) + ((s % 4096 + 4 * beat) % 4096);
      default: begin
        span = longint'((len + 1) * 4);
        base = s - (s % span);
        a    = base + ((s - base + 4 * beat) % span);
      end
    endcase
    r = a[31:0];
    return r - (r % 4);
  endfunction

  // Downstream responder: decides drives at negedge, records the handshakes the next posedge will make
  initial begin
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        m_arready = 1'b0; m_rvalid = 1'b0; ds_busy = 0; ar_hs = 0; r_hs = 0;
      end else begin
        if (ar_hs) begin ds_busy = 1; ds_wait = $urandom_range(0, 3); end
        if (r_hs) m_rvalid = 1'b0;
        m_arready = !ds_busy && ($urandom_range(0, 2) != 0);
        if (ds_busy && !m_rvalid) begin
          if (ds_wait == 0) begin
            m_rvalid = 1'b1;
            m_rdata  = ds_base + 32'(ds_cnt);
            m_rresp  = (ds_cnt == ds_err_beat) ? 2'b10 : 2'b00;
          end else ds_wait--;
        end
        ar_hs = m_arvalid && m_arready;
        if (ar_hs) ds_addr_q.push_back(m_araddr);
        r_hs = m_rvalid && m_rready;
        if (r_hs) begin ds_busy = 0; ds_cnt++; end
      end
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      n_checks++;
      assert (!(m_arvalid && m_rready)) else begin
        n_fail++;
        $error("FAIL mar_mr_overlap: observed arvalid=%0b rready=%0b expected not both", m_arvalid, m_rready);
      end
      if (in_err) begin
        n_checks++;
        assert (m_arvalid === 1'b0) else begin
          n_fail++;
          $error("FAIL err_no_downstream: observed m_arvalid=%0b expected 0", m_arvalid);
        end
      end
    end
  end

  task automatic start_burst(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input logic [31:0] base, input int err_beat);
    int t;
    cur_id = id; cur_addr = addr; cur_len = len; cur_burst = burst;
    cur_illegal = model_illegal(addr, len, size, burst);
    ds_base = base; ds_err_beat = err_beat; ds_cnt = 0; ds_addr_q.delete();
    s_arid = id; s_araddr = addr; s_arlen = 8'(len); s_arsize = size; s_arburst = burst;
    s_arvalid = 1'b1;
    t = 0;
    while (!s_arready && t < TMO) begin @(posedge clk); #1; t++; end
    chk("ar_accept_timeout", 64'(t < TMO), 64'd1);
    @(posedge clk); #1;
    s_arvalid = 1'b0; s_araddr = $urandom; s_arlen = 8'($urandom);
    in_err = cur_illegal;
    chk("ar_ready_drop", 64'(s_arready), 64'd0);
    chk("busy_after_ar", 64'(busy_o), 64'd1);
    if (cur_illegal) begin
      chk("err_rvalid_t1", 64'(s_rvalid), 64'd1);
    end else begin
      chk("issue_arvalid_t1", 64'(m_arvalid), 64'd1);
      chk("issue_addr_beat0", 64'(m_araddr), 64'(model_addr(addr, burst, len, 0)));
    end
  endtask

  task automatic collect_beat(input int b, input bit hold, input int stall);
    int t;
    logic [31:0] d;
    logic [1:0]  rr;
    logic        rl;
    logic [31:0] exp_d;
    t = 0;
    while (!s_rvalid && t < TMO) begin @(posedge clk); #1; t++; end
    chk($sformatf("rvalid_timeout_b%0d", b), 64'(t < TMO), 64'd1);
    if (cur_illegal) chk($sformatf("err_beat_gap_b%0d", b), 64'(t), 64'd0);
    exp_d = cur_illegal ? 32'd0 : ds_base + 32'(b);
    chk($sformatf("rid_b%0d", b), 64'(s_rid), 64'(cur_id));
    chk($sformatf("rdata_b%0d", b), 64'(s_rdata), 64'(exp_d));
    chk($sformatf("rresp_b%0d", b), 64'(s_rresp), (cur_illegal || b == ds_err_beat) ? 64'd2 : 64'd0);
    chk($sformatf("rlast_b%0d", b), 64'(s_rlast), 64'(b == cur_len));
    chk($sformatf("arready_in_burst_b%0d", b), 64'(s_arready), 64'd0);
    d = s_rdata; rr = s_rresp; rl = s_rlast;
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      chk("stall_rvalid", 64'(s_rvalid), 64'd1);
      chk("stall_rdata", 64'({s_rdata, s_rresp, s_rlast}), 64'({d, rr, rl}));
      chk("stall_no_arvalid", 64'(m_arvalid), 64'd0);
    end
    s_rready = 1'b1;
    @(posedge clk); #1;
    s_rready = hold;
    if (b == cur_len) begin
      chk("arready_after_last", 64'(s_arready), 64'd1);
      chk("idle_after_last", 64'({busy_o, s_rvalid}), 64'd0);
    end else if (cur_illegal) begin
      chk("err_next_rvalid", 64'(s_rvalid), 64'd1);
    end else begin
      chk("rvalid_drop", 64'(s_rvalid), 64'd0);
      chk("next_arvalid_t1", 64'(m_arvalid), 64'd1);
      chk($sformatf("issue_addr_b%0d", b + 1), 64'(m_araddr),
          64'(model_addr(cur_addr, cur_burst, cur_len, b + 1)));
    end
  endtask

  task automatic finish_burst();
    int n_exp = cur_illegal ? 0 : cur_len + 1;
    chk("ds_read_count", 64'(ds_addr_q.size()), 64'(n_exp));
    for (int i = 0; i < n_exp && i < ds_addr_q.size(); i++)
      chk($sformatf("ds_addr_%0d", i), 64'(ds_addr_q[i]), 64'(model_addr(cur_addr, cur_burst, cur_len, i)));
    in_err = 0;
  endtask

  task automatic run_burst(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [31:0] base,
                           input int err_beat, input bit hold, input int stall_beat,
                           input int stall_len, input bit rnd_stall);
    int st;
    start_burst(id, addr, len, size, burst, base, err_beat);
    s_rready = hold;
    for (int b = 0; b <= len; b++) begin
      st = (b == stall_beat) ? stall_len : ((rnd_stall && !hold) ? int'($urandom_range(0, 3)) : 0);
      collect_beat(b, hold, st);
    end
    s_rready = 1'b0;
    finish_burst();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_s"}, 64'({s_rid, s_rdata, s_rresp, s_rlast, s_rvalid, s_arready}), 64'd0);
    chk({tag, "_m"}, 64'({m_araddr, m_arvalid, m_rready, busy_o}), 64'd0);
  endtask

  initial begin
    int t, len, r;
    logic [1:0]  bt;
    logic [2:0]  sz;
    logic [31:0] a;
    bit          hold;

    #2 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset_initial");
    resetn = 1'b1;
    chk("arready_before_edge", 64'(s_arready), 64'd0);
    @(posedge clk); #1;
    chk("arready_after_release", 64'(s_arready), 64'd1);

    // INCR, 8 beats from 0x00, data 0xA0+i
    run_burst(4'd3, 32'h0000_0000, 7, 3'b010, 2'b01, 32'hA0, -1, 0, -1, 0, 0);
    // WRAP, 4 beats from 0x18
    run_burst(4'd6, 32'h0000_0018, 3, 3'b010, 2'b10, $urandom, -1, 0, -1, 0, 0);
    // FIXED three reads, then INCR across a 4 KB page
    run_burst(4'd1, 32'h0000_0040, 2, 3'b010, 2'b00, $urandom, -1, 1, -1, 0, 0);
    run_burst(4'd2, 32'h0000_0FFC, 1, 3'b010, 2'b01, $urandom, -1, 0, -1, 0, 0);
    // Illegal requests: bad size, reserved burst, bad wrap length, unaligned wrap
    run_burst(4'd9, 32'h0000_1000, 1, 3'b011, 2'b01, $urandom, -1, 1, -1, 0, 0);
    run_burst(4'd4, 32'h0000_2000, 0, 3'b010, 2'b11, $urandom, -1, 0, -1, 0, 0);
    run_burst(4'd5, 32'h0000_3000, 2, 3'b010, 2'b10, $urandom, -1, 1, -1, 0, 0);
    run_burst(4'd7, 32'h0000_3002, 3, 3'b010, 2'b10, $urandom, -1, 0, -1, 0, 0);
    // Backpressure on beat 1, SLVERR on beat 2
    run_burst(4'd8, 32'h0000_0100, 3, 3'b010, 2'b01, $urandom, 1, 0, 0, 20, 0);

    // Reset while the third downstream read is outstanding
    start_burst(4'd5, 32'h0000_0200, 7, 3'b010, 2'b01, $urandom, -1);
    collect_beat(0, 0, 0);
    collect_beat(1, 0, 0);
    t = 0;
    while (!m_rready && t < TMO) begin @(posedge clk); #1; t++; end
    chk("wait_r_beat3_timeout", 64'(t < TMO), 64'd1);
    resetn = 1'b0;
    #1;
    check_outputs_zero("reset_async");
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset_held");
    in_err = 0;
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("arready_after_midburst_reset", 64'(s_arready), 64'd1);
    run_burst(4'd10, 32'h0000_0300, 0, 3'b010, 2'b01, $urandom, -1, 0, -1, 0, 0);

    // Random bursts against the reference model
    for (int k = 0; k < 40; k++) begin
      r  = $urandom_range(0, 9);
      bt = (r < 4) ? 2'b01 : (r < 6) ? 2'b00 : (r < 9) ? 2'b10 : 2'b11;
      a  = $urandom;
      if (bt == 2'b10) begin
        if ($urandom_range(0, 4) != 0) begin
          r = $urandom_range(0, 3);
          len = (1 << (r + 1)) - 1;
          a = a - (a % 4);
        end else len = $urandom_range(0, 15);
      end else begin
        len = $urandom_range(0, 15);
        if (bt == 2'b01 && $urandom_range(0, 2) == 0) a = a - (a % 4096) + 4096 - 4 * $urandom_range(1, 6);
      end
      sz   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
      hold = ($urandom_range(0, 1) == 1);
      run_burst(4'($urandom), a, len, sz, bt, $urandom, $urandom_range(0, len + 3), hold, -1, 0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
